pw_entry_sequencer: RTL and testbench

Sequences the password handshake for the parking controller. On a pwstart rising edge it collects keypad digits, compares them against the stored key, and returns a one-cycle pwdone with a pw_correct verdict. It also enforces an inactivity timeout and a lockout after repeated failures. It sits between the keypad/button debouncers and the parking controller's pwstart/pwdone/pw_correct interface.

---
 rtl/pw_entry_sequencer.sv | 223 ++++++++++++++++++++++
 tb/tb_pw_entry_sequencer.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pw_entry_sequencer.sv
//==============================================================================
// pw_entry_sequencer
//   Collects keypad digits after a pwstart rising edge, compares them with the
//   stored key and returns a one-cycle pwdone with a registered verdict.
//   Enforces an inter-digit inactivity timeout and a lockout after repeated
//   failures.
// Revision: 1.0
//==============================================================================
`default_nettype none

module pw_entry_sequencer #(
  parameter int PW_DIGITS   = 4,
  parameter int DIGIT_W     = 4,
  parameter int TIMEOUT_CYC = 1000,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYC    = 5000
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         pwstart,
  input  logic [DIGIT_W-1:0]           digit_in,
  input  logic                         digit_valid,
  input  logic                         clear,
  input  logic [PW_DIGITS*DIGIT_W-1:0] pw_key,
  output logic                         pwdone,
  output logic                         pw_correct,
  output logic                         locked,
  output logic                         busy,
  output logic [2:0]                   digit_cnt
);

  localparam int KEY_W  = PW_DIGITS * DIGIT_W;
  localparam int CNT_W  = 4;
  localparam int TMR_W  = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int LCK_W  = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [CNT_W-1:0]  c_LAST_DIGIT = CNT_W'(PW_DIGITS - 1);
  localparam logic [TMR_W-1:0]  c_TMR_LAST   = TMR_W'(TIMEOUT_CYC - 1);
  localparam logic [LCK_W-1:0]  c_LCK_LAST   = LCK_W'(LOCK_CYC - 1);
  localparam logic [FAIL_W-1:0] c_FAIL_MAX   = FAIL_W'(MAX_FAIL);
  localparam logic [FAIL_W-1:0] c_FAIL_LOCK  = FAIL_W'(MAX_FAIL - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_CHECK   = 3'd2,
    S_DONE    = 3'd3,
    S_LOCK    = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_pwstart_d;
  logic [CNT_W-1:0]    r_cnt;
  logic [TMR_W-1:0]    r_timer;
  logic [LCK_W-1:0]    r_lock_cnt;
  logic [FAIL_W-1:0]   r_fail_cnt;
  logic [KEY_W-1:0]    r_buf;
  logic                r_pwdone;
  logic                r_pw_correct;

  logic                w_start_edge;
  logic                w_cnt_clr;
  logic                w_cnt_inc;
  logic                w_tmr_clr;
  logic                w_tmr_inc;
  logic                w_done_set;
  logic                w_verdict;
  logic                w_fail_clr;
  logic                w_fail_inc;
  logic                w_lock_clr;
  logic                w_lock_inc;

  assign w_start_edge = pwstart & ~r_pwstart_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_tmr_clr    = 1'b0;
    w_tmr_inc    = 1'b0;
    w_done_set   = 1'b0;
    w_verdict    = 1'b0;
    w_fail_clr   = 1'b0;
    w_fail_inc   = 1'b0;
    w_lock_clr   = 1'b0;
    w_lock_inc   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_start_edge) begin
          w_next_state = S_COLLECT;
          w_cnt_clr    = 1'b1;
          w_tmr_clr    = 1'b1;
        end
      end
      S_COLLECT: begin
        // A requester abort outranks every keypad event.
        if (!pwstart) begin
          w_next_state = S_IDLE;
        end else if (clear) begin
          w_cnt_clr = 1'b1;
          w_tmr_clr = 1'b1;
        end else if (digit_valid) begin
          w_cnt_inc = 1'b1;
          w_tmr_clr = 1'b1;
          if (r_cnt == c_LAST_DIGIT) begin
            w_next_state = S_CHECK;
          end
        end else if (r_timer == c_TMR_LAST) begin
          w_next_state = S_DONE;
          w_done_set   = 1'b1;
          w_verdict    = 1'b0;
        end else begin
          w_tmr_inc = 1'b1;
        end
      end
      S_CHECK: begin
        w_next_state = S_DONE;
        w_done_set   = 1'b1;
        w_verdict    = (r_buf == pw_key);
      end
      S_DONE: begin
        if (r_pw_correct) begin
          w_fail_clr   = 1'b1;
          w_next_state = S_IDLE;
        end else begin
          w_fail_inc = 1'b1;
          if (r_fail_cnt >= c_FAIL_LOCK) begin
            w_next_state = S_LOCK;
            w_lock_clr   = 1'b1;
          end else begin
            w_next_state = S_IDLE;
          end
        end
      end
      S_LOCK: begin
        // Reject new requests immediately so the requester never stalls.
        if (w_start_edge) begin
          w_done_set = 1'b1;
          w_verdict  = 1'b0;
        end
        if (r_lock_cnt == c_LCK_LAST) begin
          w_next_state = S_IDLE;
          w_fail_clr   = 1'b1;
        end else begin
          w_lock_inc = 1'b1;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pwstart_d  <= 1'b0;
      r_cnt        <= '0;
      r_timer      <= '0;
      r_lock_cnt   <= '0;
      r_fail_cnt   <= '0;
      r_buf        <= '0;
      r_pwdone     <= 1'b0;
      r_pw_correct <= 1'b0;
    end else begin
      r_pwstart_d <= pwstart;

      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      for (int i = 0; i < PW_DIGITS; i++) begin
        if (w_cnt_inc && (r_cnt == CNT_W'(i))) begin
          r_buf[i*DIGIT_W +: DIGIT_W] <= digit_in;
        end
      end

      if (w_tmr_clr) begin
        r_timer <= '0;
      end else if (w_tmr_inc) begin
        r_timer <= r_timer + TMR_W'(1);
      end

      if (w_lock_clr) begin
        r_lock_cnt <= '0;
      end else if (w_lock_inc) begin
        r_lock_cnt <= r_lock_cnt + LCK_W'(1);
      end

      if (w_fail_clr) begin
        r_fail_cnt <= '0;
      end else if (w_fail_inc && (r_fail_cnt != c_FAIL_MAX)) begin
        r_fail_cnt <= r_fail_cnt + FAIL_W'(1);
      end

      r_pwdone <= w_done_set;
      if (w_done_set) begin
        r_pw_correct <= w_verdict;
      end
    end
  end

  assign pwdone     = r_pwdone;
  assign pw_correct = r_pw_correct;
  assign locked     = (r_state == S_LOCK);
  assign busy       = (r_state == S_COLLECT) || (r_state == S_CHECK);
  // The display digit saturates at 7 for 8-digit passwords.
  assign digit_cnt  = r_cnt[3] ? 3'd7 : r_cnt[2:0];

endmodule

`default_nettype wire

// File: tb/tb_pw_entry_sequencer.sv
//==============================================================================
// tb_pw_entry_sequencer
//   Scenario bench for pw_entry_sequencer with a session-level reference model.
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_pw_entry_sequencer;

  localparam int PW_DIGITS   = 4;
  localparam int DIGIT_W     = 4;
  localparam int TIMEOUT_CYC = 1000;
  localparam int MAX_FAIL    = 3;
  localparam int LOCK_CYC    = 5000;

  logic        clk;
  logic        rst;
  logic        pwstart;
  logic [3:0]  digit_in;
  logic        digit_valid;
  logic        clear;
  logic [15:0] pw_key;
  logic        pwdone;
  logic        pw_correct;
  logic        locked;
  logic        busy;
  logic [2:0]  digit_cnt;

  int tests;
  int fails;
  int cyc;
  int n_done;
  int n_consec;
  logic prev_done;
  int m_fail;

  pw_entry_sequencer #(
    .PW_DIGITS  (PW_DIGITS),
    .DIGIT_W    (DIGIT_W),
    .TIMEOUT_CYC(TIMEOUT_CYC),
    .MAX_FAIL   (MAX_FAIL),
    .LOCK_CYC   (LOCK_CYC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .pwstart    (pwstart),
    .digit_in   (digit_in),
    .digit_valid(digit_valid),
    .clear      (clear),
    .pw_key     (pw_key),
    .pwdone     (pwdone),
    .pw_correct (pw_correct),
    .locked     (locked),
    .busy       (busy),
    .digit_cnt  (digit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    n_done = 0;
    n_consec = 0;
    prev_done = 1'b0;
  end
  always @(negedge clk) begin
    if (pwdone) n_done++;
    if (pwdone && prev_done) n_consec++;
    prev_done = pwdone;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  function automatic logic [3:0] kd(input logic [15:0] k, input int i);
    return k[i*4 +: 4];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic start_session();
    pwstart = 1'b0;
    tick();
    pwstart = 1'b1;
    tick();
  endtask

  task automatic end_session();
    tick();
    pwstart = 1'b0;
    tick();
  endtask

  task automatic strobe(input logic [3:0] d);
    digit_in = d;
    digit_valid = 1'b1;
    tick();
    digit_valid = 1'b0;
    digit_in = 4'($urandom);
  endtask

  task automatic enter_word(input logic [15:0] w, input int max_gap);
    for (int i = 0; i < PW_DIGITS; i++) begin
      idle($urandom_range(0, max_gap));
      strobe(kd(w, i));
    end
  endtask

  task automatic wait_done(input int budget, output int dcyc);
    dcyc = -1;
    for (int i = 0; i < budget && dcyc < 0; i++) begin
      if (pwdone) dcyc = cyc;
      else tick();
    end
  endtask

  task automatic apply_reset();
    pwstart = 1'b0;
    digit_valid = 1'b0;
    clear = 1'b0;
    #2 rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    m_fail = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    pwstart = 1'b0;
    digit_valid = 1'b0;
    clear = 1'b0;
    digit_in = 4'h0;
    pw_key = 16'h0;
    m_fail = 0;
    tick();
    tick();
    tests++; if (pwdone !== 1'b0) begin fails++; $display("FAIL reset_pwdone: got %b expected 0", pwdone); end
    tests++; if (pw_correct !== 1'b0) begin fails++; $display("FAIL reset_pw_correct: got %b expected 0", pw_correct); end
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL reset_locked: got %b expected 0", locked); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b expected 0", busy); end
    tests++; if (digit_cnt !== 3'd0) begin fails++; $display("FAIL reset_digit_cnt: got %0d expected 0", digit_cnt); end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_correct();
    int d;
    int last;
    logic [15:0] k;
    logic [15:0] ent;
    logic exp_ok;
    // The first entered digit lands in the low nibble of the key.
    pw_key = 16'h4321;
    start_session();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL start_busy: got %b expected 1", busy); end
    enter_word(16'h4321, 0);
    last = cyc - 1;
    tests++; if (digit_cnt !== 3'd4) begin fails++; $display("FAIL direct_digit_cnt: got %0d expected 4", digit_cnt); end
    wait_done(10, d);
    tests++; if (d !== last + 2) begin fails++; $display("FAIL direct_latency: got %0d expected %0d", d, last + 2); end
    tests++; if (pw_correct !== 1'b1) begin fails++; $display("FAIL direct_verdict: got %b expected 1", pw_correct); end
    tests++; if (digit_cnt !== 3'd4) begin fails++; $display("FAIL direct_cnt_at_done: got %0d expected 4", digit_cnt); end
    end_session();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL direct_idle_busy: got %b expected 0", busy); end

    for (int s = 0; s < 6; s++) begin
      k = 16'($urandom);
      ent = (m_fail == MAX_FAIL - 1 || $urandom_range(0, 1) == 1) ? k : (k ^ (16'h1 << $urandom_range(0, 15)));
      pw_key = k;
      start_session();
      enter_word(ent, 4);
      last = cyc - 1;
      wait_done(10, d);
      exp_ok = (ent == k);
      tests++; if (d !== last + 2) begin fails++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", s, d, last + 2); end
      tests++; if (pw_correct !== exp_ok) begin fails++; $display("FAIL rand_verdict[%0d]: got %b expected %b", s, pw_correct, exp_ok); end
      m_fail = exp_ok ? 0 : m_fail + 1;
      end_session();
      tests++; if (locked !== 1'b0) begin fails++; $display("FAIL rand_locked[%0d]: got %b expected 0", s, locked); end
    end
  endtask

  task automatic test_clear();
    int d;
    int last;
    int r;
    logic [3:0] dv;
    logic [3:0] q[$];
    logic good;
    apply_reset();
    pw_key = 16'h4321;
    start_session();
    strobe(4'h1);
    strobe(4'h2);
    tests++; if (digit_cnt !== 3'd2) begin fails++; $display("FAIL clear_pre_cnt: got %0d expected 2", digit_cnt); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tests++; if (digit_cnt !== 3'd0) begin fails++; $display("FAIL clear_cnt: got %0d expected 0", digit_cnt); end
    enter_word(16'h4321, 2);
    wait_done(10, d);
    tests++; if (pw_correct !== 1'b1) begin fails++; $display("FAIL clear_verdict: got %b expected 1", pw_correct); end
    end_session();

    start_session();
    strobe(4'h5);
    clear = 1'b1;
    digit_valid = 1'b1;
    digit_in = 4'h7;
    tick();
    clear = 1'b0;
    digit_valid = 1'b0;
    tests++; if (digit_cnt !== 3'd0) begin fails++; $display("FAIL clear_vs_valid: got %0d expected 0", digit_cnt); end
    pwstart = 1'b0;
    tick();

    pw_key = 16'($urandom);
    start_session();
    for (int e = 0; q.size() < PW_DIGITS; e++) begin
      idle($urandom_range(0, 3));
      r = (e >= 20) ? 2 : $urandom_range(0, 5);
      dv = ($urandom_range(0, 2) != 0) ? kd(pw_key, q.size()) : 4'($urandom);
      digit_in = dv;
      digit_valid = (r != 0);
      clear = (r <= 1);
      tick();
      digit_valid = 1'b0;
      clear = 1'b0;
      if (r <= 1) q.delete();
      else q.push_back(dv);
      tests++; if (digit_cnt !== 3'(q.size())) begin fails++; $display("FAIL rand_clear_cnt[%0d]: got %0d expected %0d", e, digit_cnt, q.size()); end
    end
    last = cyc - 1;
    good = 1'b1;
    for (int i = 0; i < PW_DIGITS; i++) if (q[i] !== kd(pw_key, i)) good = 1'b0;
    wait_done(10, d);
    tests++; if (d !== last + 2) begin fails++; $display("FAIL rand_clear_latency: got %0d expected %0d", d, last + 2); end
    tests++; if (pw_correct !== good) begin fails++; $display("FAIL rand_clear_verdict: got %b expected %b", pw_correct, good); end
    end_session();
  endtask

  task automatic test_timeout();
    int s;
    int d;
    int nd;
    int last;
    apply_reset();
    pw_key = 16'($urandom);
    start_session();
    s = cyc;
    wait_done(TIMEOUT_CYC + 100, d);
    tests++; if (d !== s + TIMEOUT_CYC) begin fails++; $display("FAIL timeout_cycle: got %0d expected %0d", d, s + TIMEOUT_CYC); end
    tests++; if (pw_correct !== 1'b0) begin fails++; $display("FAIL timeout_verdict: got %b expected 0", pw_correct); end
    end_session();

    start_session();
    tick();
    nd = n_done;
    for (int i = 0; i < PW_DIGITS; i++) begin
      idle(TIMEOUT_CYC - 2);
      strobe(kd(pw_key, i));
    end
    last = cyc - 1;
    tests++; if (n_done !== nd) begin fails++; $display("FAIL slow_digits_no_timeout: got %0d pulses expected 0", n_done - nd); end
    wait_done(10, d);
    tests++; if (d !== last + 2) begin fails++; $display("FAIL slow_digits_latency: got %0d expected %0d", d, last + 2); end
    tests++; if (pw_correct !== 1'b1) begin fails++; $display("FAIL slow_digits_verdict: got %b expected 1", pw_correct); end
    end_session();
  endtask

  task automatic test_lockout();
    int d;
    logic [15:0] bad;
    apply_reset();
    pw_key = 16'($urandom);
    for (int s = 0; s < MAX_FAIL; s++) begin
      bad = pw_key ^ (16'h1 << $urandom_range(0, 15));
      start_session();
      enter_word(bad, 3);
      wait_done(10, d);
      tests++; if (pw_correct !== 1'b0 || d < 0) begin fails++; $display("FAIL lock_verdict[%0d]: got %b expected 0", s, pw_correct); end
      m_fail++;
      if (s < MAX_FAIL - 1) begin
        end_session();
        tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_early[%0d]: got %b expected 0", s, locked); end
      end
    end
    tick();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_entered: got %b expected 1", locked); end
    pwstart = 1'b0;
    tick();
    pwstart = 1'b1;
    tick();
    tests++; if (pwdone !== 1'b1) begin fails++; $display("FAIL lock_reject_done: got %b expected 1", pwdone); end
    tests++; if (pw_correct !== 1'b0) begin fails++; $display("FAIL lock_reject_verdict: got %b expected 0", pw_correct); end
    tick();
    tests++; if (pwdone !== 1'b0) begin fails++; $display("FAIL lock_reject_single: got %b expected 0", pwdone); end
    pwstart = 1'b0;
    while (cyc < d + LOCK_CYC) tick();
    tests++; if (locked !== 1'b1) begin fails++; $display("FAIL lock_last_cycle: got %b expected 1", locked); end
    tick();
    tests++; if (locked !== 1'b0) begin fails++; $display("FAIL lock_released: got %b expected 0", locked); end
    m_fail = 0;
  endtask

  task automatic test_abort();
    int d;
    int nd;
    logic [15:0] bad;
    apply_reset();
    pw_key = 16'($urandom);
    for (int s = 0; s < MAX_FAIL - 1; s++) begin
      bad = pw_key ^ (16'h1 << $urandom_range(0, 15));
      start_session();
      enter_word(bad, 2);
      wait_done(10, d);
      tests++; if (pw_correct !== 1'b0 || d < 0) begin fails++; $display("FAIL abort_pre_verdict[%0d]: got %b expected 0", s, pw_correct); end
      m_fail++;
      end_session();
    end
    start_session();
    strobe(kd(pw_key, 0));
    strobe(kd(pw_key, 1));
    nd = n_done;
    pwstart = 1'b0;
    tick();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b expected 0", busy); end
    idle(10);
    tests++; if (n_done !== nd) begin fails++; $display("FAIL abort_no_done: got %0d pulses expected 0", n_done - nd); end
    // fail count survives the abort, so one more failure must lock.
    bad = pw_key ^ 16'h0100;
    start_session();
    enter_word(bad, 1);
    wait_done(10, d);
    m_fail++;
    tick();
    tests++; if (locked !== (m_fail >= MAX_FAIL)) begin fails++; $display("FAIL abort_fail_kept: got %b expected %b", locked, m_fail >= MAX_FAIL); end
    pwstart = 1'b0;

    apply_reset();
    start_session();
    strobe(4'h9);
    strobe(4'h8);
    #2 rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL async_rst_busy: got %b expected 0", busy); end
    tests++; if (digit_cnt !== 3'd0) begin fails++; $display("FAIL async_rst_cnt: got %0d expected 0", digit_cnt); end
    tests++; if (pwdone !== 1'b0 || pw_correct !== 1'b0 || locked !== 1'b0) begin fails++; $display("FAIL async_rst_outputs: got %b%b%b expected 000", pwdone, pw_correct, locked); end
    pwstart = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    m_fail = 0;
  endtask

  task automatic test_back_to_back();
    int d;
    int nd;
    int last;
    apply_reset();
    pw_key = 16'($urandom);
    start_session();
    enter_word(pw_key, 0);
    last = cyc - 1;
    wait_done(10, d);
    tests++; if (d !== last + 2) begin fails++; $display("FAIL b2b_latency: got %0d expected %0d", d, last + 2); end
    tick();
    nd = n_done;
    for (int i = 0; i < 3; i++) begin
      tests++; if (busy !== 1'b0) begin fails++; $display("FAIL b2b_no_restart[%0d]: got %b expected 0", i, busy); end
      tick();
    end
    tests++; if (n_done !== nd) begin fails++; $display("FAIL b2b_no_done: got %0d pulses expected 0", n_done - nd); end
    pwstart = 1'b0;
    tick();
    pwstart = 1'b1;
    tick();
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL b2b_new_edge: got %b expected 1", busy); end
    enter_word(pw_key, 0);
    last = cyc - 1;
    wait_done(10, d);
    tests++; if (d !== last + 2 || pw_correct !== 1'b1) begin fails++; $display("FAIL b2b_second: got cycle %0d verdict %b expected cycle %0d verdict 1", d, pw_correct, last + 2); end
    end_session();
    tests++; if (n_consec !== 0) begin fails++; $display("FAIL pwdone_consecutive: got %0d expected 0", n_consec); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_correct();
    test_clear();
    test_timeout();
    test_lockout();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
